o_delay_tap_ctrl: RTL and testbench

//  Tap-control initiator for the output delay primitive. Drives DLY_LOAD/DLY_ADJ/DLY_INCDEC
//  and reads back DLY_TAP_VALUE.

---
 rtl/o_delay_tap_ctrl_if.sv | 25 ++
 rtl/o_delay_tap_ctrl.sv | 161 ++++++++++++++++
 tb/tb_o_delay_tap_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/o_delay_tap_ctrl_if.sv
// Handshake and tap-control bundle between a requester, the tap controller and the O_DELAY.
// The requester (master) drives targets, load requests and the tap feedback; the controller is the slave.
interface o_delay_tap_ctrl_if;
    logic [5:0] TARGET_TAP;
    logic       TARGET_VALID;
    logic       TARGET_READY;
    logic       LOAD_REQ;
    logic [5:0] DLY_TAP_VALUE;
    logic       DLY_LOAD;
    logic       DLY_ADJ;
    logic       DLY_INCDEC;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    modport master (
        output TARGET_TAP, TARGET_VALID, LOAD_REQ, DLY_TAP_VALUE,
        input  TARGET_READY, DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR
    );

    modport slave (
        input  TARGET_TAP, TARGET_VALID, LOAD_REQ, DLY_TAP_VALUE,
        output TARGET_READY, DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/o_delay_tap_ctrl.sv
// Closed-loop tap controller for an O_DELAY: steps DLY_ADJ until the feedback tap matches the target.
// Define ODLY_CTRL_TIMEOUT_EN to abort a move with a sticky ERROR after 64 unsuccessful steps.
module o_delay_tap_ctrl #(
    parameter int DELAY  = 0,
    parameter int SETTLE = 3
) (
    input  logic                  CLK_IN,
    input  logic                  RST,
    o_delay_tap_ctrl_if.slave     bus
);

    generate
        if (DELAY < 0 || DELAY > 63) begin : g_bad_delay
            $fatal(1, "o_delay_tap_ctrl: DELAY must be within 0-63");
        end
        if (SETTLE < 2 || SETTLE > 15) begin : g_bad_settle
            $fatal(1, "o_delay_tap_ctrl: SETTLE must be within 2-15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_STEP,
        ST_SETTLE,
        ST_LOAD,
        ST_LWAIT,
        ST_FINISH
    } state_t;

    state_t     state_reg;
    logic [5:0] target_reg;
    logic [3:0] wait_reg;
    logic       ready_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       load_reg;
    logic       adj_reg;
    logic       incdec_reg;

`ifdef ODLY_CTRL_TIMEOUT_EN
    logic [6:0] step_cnt_reg;
    logic       error_reg;
`endif

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_reg  <= ST_IDLE;
            target_reg <= '0;
            wait_reg   <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            load_reg   <= 1'b0;
            adj_reg    <= 1'b0;
            incdec_reg <= 1'b0;
`ifdef ODLY_CTRL_TIMEOUT_EN
            step_cnt_reg <= '0;
            error_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.LOAD_REQ) begin
                        load_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
`ifdef ODLY_CTRL_TIMEOUT_EN
                        error_reg <= 1'b0;
`endif
                    end else if (bus.TARGET_VALID && ready_reg) begin
                        target_reg <= bus.TARGET_TAP;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_CMP;
`ifdef ODLY_CTRL_TIMEOUT_EN
                        error_reg    <= 1'b0;
                        step_cnt_reg <= '0;
`endif
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                ST_CMP: begin
                    if (bus.DLY_TAP_VALUE == target_reg) begin
                        incdec_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_FINISH;
`ifdef ODLY_CTRL_TIMEOUT_EN
                    end else if (step_cnt_reg == 7'd64) begin
                        // Feedback never converged: give up without a DONE.
                        incdec_reg <= 1'b0;
                        error_reg  <= 1'b1;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_IDLE;
`endif
                    end else begin
                        incdec_reg <= (target_reg > bus.DLY_TAP_VALUE);
                        adj_reg    <= 1'b1;
                        state_reg  <= ST_STEP;
`ifdef ODLY_CTRL_TIMEOUT_EN
                        step_cnt_reg <= step_cnt_reg + 7'd1;
`endif
                    end
                end
                ST_STEP: begin
                    adj_reg   <= 1'b0;
                    wait_reg  <= SETTLE_LAST;
                    state_reg <= ST_SETTLE;
                end
                // Let the delay's edge detector apply the step before the next compare.
                ST_SETTLE: begin
                    if (wait_reg == 4'd0) begin
                        state_reg <= ST_CMP;
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                ST_LOAD: begin
                    load_reg  <= 1'b0;
                    wait_reg  <= SETTLE_LAST;
                    state_reg <= ST_LWAIT;
                end
                ST_LWAIT: begin
                    if (wait_reg == 4'd0) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_FINISH;
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
                ST_FINISH: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.TARGET_READY = ready_reg;
    assign bus.BUSY         = busy_reg;
    assign bus.DONE         = done_reg;
    assign bus.DLY_LOAD     = load_reg;
    assign bus.DLY_ADJ      = adj_reg;
    assign bus.DLY_INCDEC   = incdec_reg;
`ifdef ODLY_CTRL_TIMEOUT_EN
    assign bus.ERROR        = error_reg;
`else
    assign bus.ERROR        = 1'b0;
`endif

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// Scoreboard bench for o_delay_tap_ctrl with a behavioural O_DELAY (2-flop edge detect, saturating tap).
// Stimulus pushes expected completions; a negedge monitor pops them on DONE or a rising ERROR.
module tb_o_delay_tap_ctrl;

    typedef struct {
        bit is_err;
        int pulses;
        int loads;
        int tap;
        bit dir;
        int lat;
        int start;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tie0;
    logic [5:0] tap = 6'd0;
    logic adj_s1 = 1'b0, adj_s2 = 1'b0, load_s1 = 1'b0, load_s2 = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   adj_cnt = 0, load_cnt = 0, last_adj = 0;
    int   adj_total = 0, load_total = 0;
    bit   err_prev = 1'b0;
    exp_t q[$];

    o_delay_tap_ctrl_if bus();

    o_delay_tap_ctrl #(.DELAY(10), .SETTLE(3)) dut (
        .CLK_IN (clk),
        .RST    (rst_n),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural delay: pulses are seen through a 2-flop rising-edge detector.
    always @(posedge clk) begin
        adj_s1  <= bus.DLY_ADJ;
        adj_s2  <= adj_s1;
        load_s1 <= bus.DLY_LOAD;
        load_s2 <= load_s1;
        if (load_s1 && !load_s2)
            tap <= 6'd10;
        else if (adj_s1 && !adj_s2)
            tap <= bus.DLY_INCDEC ? ((tap == 6'd63) ? tap : tap + 6'd1)
                                  : ((tap == 6'd0)  ? tap : tap - 6'd1);
    end

    assign bus.DLY_TAP_VALUE = tie0 ? 6'd0 : tap;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            adj_cnt  = 0;
            load_cnt = 0;
            err_prev = 1'b0;
        end else begin
            if (bus.DLY_ADJ) begin
                adj_total++;
                if (adj_cnt > 0) check("adj_spacing", cyc - last_adj, 5);
                if (q.size() > 0) check("adj_incdec", int'(bus.DLY_INCDEC), int'(q[0].dir));
                adj_cnt++;
                last_adj = cyc;
            end
            if (bus.DLY_LOAD) begin
                load_total++;
                load_cnt++;
            end
            if (bus.DONE || (bus.ERROR && !err_prev)) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: done=%0b error=%0b with nothing expected (cycle %0d)",
                             bus.DONE, bus.ERROR, cyc);
                end else begin
                    e = q.pop_front();
                    check("event_kind", bus.DONE ? 0 : 1, int'(e.is_err));
                    check("adj_pulses", adj_cnt, e.pulses);
                    check("load_pulses", load_cnt, e.loads);
                    check("latency", cyc - e.start, e.lat);
                    if (bus.DONE) begin
                        check("final_tap", int'(tap), e.tap);
                        check("incdec_idle", int'(bus.DLY_INCDEC), 0);
                        check("error_on_done", int'(bus.ERROR), 0);
                    end else begin
                        check("ready_on_error", int'(bus.TARGET_READY), 1);
                        check("busy_on_error", int'(bus.BUSY), 0);
                    end
                    $display("[TB] event %s pulses=%0d loads=%0d tap=%0d latency=%0d",
                             bus.DONE ? "done" : "error", adj_cnt, load_cnt, tap, cyc - e.start);
                end
                adj_cnt  = 0;
                load_cnt = 0;
            end
            err_prev = bus.ERROR;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.TARGET_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.TARGET_READY) check("ready_timeout", 0, 1);
    endtask

    task automatic send_target(input logic [5:0] t, input bit push, input exp_t e);
        exp_t x;
        wait_ready();
        bus.TARGET_TAP   = t;
        bus.TARGET_VALID = 1'b1;
        if (push) begin
            x = e;
            x.start = cyc;
            q.push_back(x);
        end
        @(posedge clk);
        #1 bus.TARGET_VALID = 1'b0;
    endtask

    task automatic send_load(input exp_t e);
        exp_t x;
        wait_ready();
        bus.LOAD_REQ = 1'b1;
        x = e;
        x.start = cyc;
        q.push_back(x);
        @(posedge clk);
        #1 bus.LOAD_REQ = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d expected events still pending after %0d cycles", q.size(), budget);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},  int'(bus.TARGET_READY), 0);
        check({tag, "_busy"},   int'(bus.BUSY), 0);
        check({tag, "_done"},   int'(bus.DONE), 0);
        check({tag, "_error"},  int'(bus.ERROR), 0);
        check({tag, "_adj"},    int'(bus.DLY_ADJ), 0);
        check({tag, "_load"},   int'(bus.DLY_LOAD), 0);
        check({tag, "_incdec"}, int'(bus.DLY_INCDEC), 0);
    endtask

    initial begin
        exp_t e;
        int n;
        rst_n            = 1'b0;
        tie0             = 1'b0;
        bus.TARGET_TAP   = 6'd5;
        bus.TARGET_VALID = 1'b1;
        bus.LOAD_REQ     = 1'b0;

        // 1: reset with VALID held, then READY one cycle after release
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n            = 1'b1;
        bus.TARGET_VALID = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(bus.TARGET_READY), 1);
        check("busy_after_reset", int'(bus.BUSY), 0);
        repeat (3) @(negedge clk);
        check("no_adj_after_reset", adj_total, 0);
        check("no_load_after_reset", load_total, 0);

        // 2: load preset 10: DONE at SETTLE+2 cycles
        e = '{is_err: 0, pulses: 0, loads: 1, tap: 10, dir: 0, lat: 5, start: 0};
        send_load(e);
        wait_drain(50);

        // 3: 10 -> 13, three increments
        e = '{is_err: 0, pulses: 3, loads: 0, tap: 13, dir: 1, lat: 17, start: 0};
        send_target(6'd13, 1'b1, e);
        wait_drain(100);

        // 4: already at target, then 13 -> 0
        e = '{is_err: 0, pulses: 0, loads: 0, tap: 13, dir: 0, lat: 2, start: 0};
        send_target(6'd13, 1'b1, e);
        wait_drain(50);
        e = '{is_err: 0, pulses: 13, loads: 0, tap: 0, dir: 0, lat: 67, start: 0};
        send_target(6'd0, 1'b1, e);
        wait_drain(200);

        // 5: abort a 0 -> 5 move after two steps, then converge 2 -> 7
        send_target(6'd5, 1'b0, e);
        n = 0;
        while (adj_cnt < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_two_steps", adj_cnt, 2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        e = '{is_err: 0, pulses: 5, loads: 0, tap: 7, dir: 1, lat: 27, start: 0};
        send_target(6'd7, 1'b1, e);
        wait_drain(100);

        // 6: feedback stuck at 0, target 5
        tie0 = 1'b1;
`ifdef ODLY_CTRL_TIMEOUT_EN
        e = '{is_err: 1, pulses: 64, loads: 0, tap: 0, dir: 1, lat: 322, start: 0};
        send_target(6'd5, 1'b1, e);
        wait_drain(500);
        check("error_sticky", int'(bus.ERROR), 1);
        tie0 = 1'b0;
`else
        send_target(6'd5, 1'b0, e);
        repeat (400) @(negedge clk);
        check("stuck_pulses_continue", int'(adj_cnt >= 70), 1);
        check("stuck_error_low", int'(bus.ERROR), 0);
        check("stuck_still_busy", int'(bus.BUSY), 1);
        rst_n = 1'b0;
        tie0  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
`endif

        // Model tap saturated at 63 during the stuck move; walk it down to 20
        e = '{is_err: 0, pulses: 43, loads: 0, tap: 20, dir: 0, lat: 217, start: 0};
        send_target(6'd20, 1'b1, e);
        wait_drain(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
